// File: rtl/muldiv_control.sv
// muldiv_control: iterative multiply/divide unit with its own HI/LO pair.
//
// It decodes R-type func codes when alu_op is func_op (4'b0000):
// mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
// mult/div use a shift-add / restoring sequencer, one bit per cycle:
// IDLE -> RUN (WIDTH steps) -> FIX (sign fix-up and HI/LO write) -> IDLE.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake; req_ready = ~busy
//   alu_op, func       op class and R-type func field
//   rs, rt             operands (rs is also the mthi/mtlo source)
//   busy               iterative operation in progress
//   done               one-cycle pulse after HI/LO receive a mult/div result
//   stall              muldiv request presented while busy
//   hi, lo             HI and LO registers
//
// Optional macro MULDIV_EARLY_EXIT_EN: mult leaves RUN as soon as the
// remaining multiplier bits are zero. FIX then realigns the product.
module muldiv_control #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;    // product upper half / remainder
    logic [WIDTH-1:0]   mq_q, mq_d;      // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand / divisor
    logic               is_div_q, is_div_d;
    logic               neg_p_q, neg_p_d; // product or quotient sign
    logic               neg_r_q, neg_r_d; // remainder sign
    logic               dz_q, dz_d;       // divide by zero
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    // Decode
    logic dec_hit, dec_md, dec_div, dec_sgn, dec_mthi, dec_mtlo;

    always_comb begin
        dec_hit  = 1'b0;
        dec_md   = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        if (alu_op == 4'b0000) begin
            case (func)
                6'b011000: begin dec_hit = 1'b1; dec_md = 1'b1; dec_sgn = 1'b1; end
                6'b011001: begin dec_hit = 1'b1; dec_md = 1'b1; end
                6'b011010: begin
                    dec_hit = 1'b1; dec_md = 1'b1; dec_div = 1'b1; dec_sgn = 1'b1;
                end
                6'b011011: begin dec_hit = 1'b1; dec_md = 1'b1; dec_div = 1'b1; end
                6'b010000: dec_hit = 1'b1;
                6'b010001: begin dec_hit = 1'b1; dec_mthi = 1'b1; end
                6'b010010: dec_hit = 1'b1;
                6'b010011: begin dec_hit = 1'b1; dec_mtlo = 1'b1; end
                default:   dec_hit = 1'b0;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign req_ready = ~busy;
    assign stall     = req_valid & busy & dec_hit;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    logic             accept;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted_r;
    logic [WIDTH:0]   trial;
    logic [CNT_W-1:0] cnt_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo_f, rem_f;
`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0] rem_mask;
`endif

    assign accept = req_valid & req_ready & dec_hit;
    assign rs_neg = dec_sgn & rs[WIDTH-1];
    assign rt_neg = dec_sgn & rt[WIDTH-1];
    assign rs_abs = rs_neg ? (~rs + 1'b1) : rs;
    assign rt_abs = rt_neg ? (~rt + 1'b1) : rt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        cnt_n     = cnt_q + 1'b1;
        sum       = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted_r = {acc_q, mq_q[WIDTH-1]};
        trial     = shifted_r - {1'b0, opnd_q};
`ifdef MULDIV_EARLY_EXIT_EN
        rem_mask  = {WIDTH{1'b1}} >> cnt_n;
        // Realign a product whose multiplier ran out early.
        prod      = {acc_q, mq_q} >> (WIDTH - 32'(cnt_q));
`else
        prod      = {acc_q, mq_q};
`endif
        if (neg_p_q) prod = ~prod + 1'b1;
        quo_f = neg_p_q ? (~mq_q + 1'b1) : mq_q;
        rem_f = neg_r_q ? (~acc_q + 1'b1) : acc_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_mthi) hi_d = rs;
                    if (dec_mtlo) lo_d = rs;
                    if (dec_md) begin
                        is_div_d = dec_div;
                        neg_p_d  = rs_neg ^ rt_neg;
                        neg_r_d  = rs_neg;
                        dz_d     = dec_div & (rt == '0);
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StRun;
                        if (dec_div) begin
                            mq_d   = rs_abs;
                            opnd_d = rt_abs;
                        end else begin
                            mq_d   = rt_abs;
                            opnd_d = rs_abs;
`ifdef MULDIV_EARLY_EXIT_EN
                            if (rt_abs == '0) state_d = StFix;
`endif
                        end
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_n;
                if (is_div_q) begin
                    // Restoring step: keep the trial difference when no borrow.
                    if (!trial[WIDTH]) acc_d = trial[WIDTH-1:0];
                    else               acc_d = shifted_r[WIDTH-1:0];
                    mq_d = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
                end else begin
                    acc_d = sum[WIDTH:1];
                    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
`ifdef MULDIV_EARLY_EXIT_EN
                if (!is_div_q && ((mq_d & rem_mask) == '0)) state_d = StFix;
`endif
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d = dz_q ? {WIDTH{1'b1}} : quo_f;
                    // With a zero divisor rem_f reproduces the original rs.
                    hi_d = rem_f;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_control.sv
module tb_muldiv_control;

    localparam int unsigned W = 32;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                           F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                           F_MFLO = 6'b010010, F_MTLO = 6'b010011;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   alu_op = 4'b0000;
    logic [5:0]   func = 6'b0;
    logic [W-1:0] rs = '0, rt = '0;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    muldiv_control #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alu_op(alu_op), .func(func), .rs(rs), .rt(rt), .busy(busy), .done(done),
        .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result of a mult/div, straight from the arithmetic definitions.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [31:0] q, r;
        case (f)
            F_MULT: begin
                sp = 64'($signed(a)) * 64'($signed(b));
                return sp;
            end
            F_MULTU: return {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Present one request for one clock edge. now=1 drives in the current cycle.
    task automatic send(input logic [3:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit now);
        if (!now) @(negedge clk);
        alu_op = op; func = f; rs = a; rt = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle after accept edge) in which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc > 100) begin
                check("done_timeout", {63'b0, done}, 64'd1);
                break;
            end
        end
    endtask

    task automatic check_latency(input string tag, input int cyc, input logic [5:0] f);
`ifdef MULDIV_EARLY_EXIT_EN
        if (f == F_MULT || f == F_MULTU) check(tag, 64'(cyc <= 34 && cyc >= 2), 64'd1);
        else check(tag, 64'(cyc), 64'd34);
`else
        check(tag, 64'(cyc), 64'd34);
`endif
    endtask

    // Full mult/div: start, wait, compare latency and HI/LO with the model.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit now);
        int cyc;
        logic [63:0] e;
        send(4'b0000, f, a, b, now);
        wait_done(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(cyc));
        checks--;
        check_latency({tag, "_lat"}, cyc, f);
        e = model(f, a, b);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int cyc;
        logic [5:0] fl[8];
        fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};

        // Reset state
        rst = 1'b1;
        #1;
        check("rst_ready", {63'b0, req_ready}, 64'd1);
        check("rst_status", {61'b0, busy, done, stall}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed cases
        send(4'b0000, F_MULT, 32'hFFFF_FFFD, 32'h5, 1'b0);
        check("run_busy", {63'b0, busy}, 64'd1);
        check("run_ready", {63'b0, req_ready}, 64'd0);
        wait_done(cyc);
        check_latency("mult_lat", cyc, F_MULT);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        exp_hi = hi; exp_lo = lo;
        @(negedge clk);
        check("done_pulse", {63'b0, done}, 64'd0);

        run_md("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_md("multu_small", F_MULTU, 32'd3, 32'd5, 1'b0);
        run_md("mult_zero", F_MULT, 32'h1234_5678, 32'd0, 1'b0);
        run_md("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("divu_zero", F_DIVU, 32'd7, 32'd0, 1'b0);
        check("divu_zero_val", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_md("div_zero_neg", F_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        // Back-to-back: accept in the done cycle
        run_md("b2b", F_DIVU, 32'd1000, 32'd7, 1'b1);

        // mthi while busy is dropped
        send(4'b0000, F_MULTU, 32'd11, 32'd13, 1'b0);
        repeat (4) @(negedge clk);
        alu_op = 4'b0000; func = F_MTHI; rs = 32'h1234_5678; req_valid = 1'b1;
        #1;
        check("busy_stall", {62'b0, stall, req_ready}, 64'd2);
        @(negedge clk) req_valid = 1'b0;
        wait_done(cyc);
        check("busy_mthi_hi", {hi, lo}, 64'd143);
        exp_hi = hi; exp_lo = lo;
        send(4'b0000, F_MTHI, 32'h1234_5678, 32'd0, 1'b1);
        check("mthi_hi", {hi, lo}, {32'h1234_5678, exp_lo});
        check("mthi_busy", {63'b0, busy}, 64'd0);
        exp_hi = 32'h1234_5678;

        // Non-func_op class is ignored
        send(4'b0001, F_MULT, 32'd9, 32'd9, 1'b0);
        check("ign_busy", {63'b0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        check("ign_hilo", {hi, lo}, {exp_hi, exp_lo});
        check("ign_done", {63'b0, done}, 64'd0);

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = fl[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(0, 15);
                default: ;
            endcase
            if (f == F_MTHI || f == F_MTLO || f == F_MFHI || f == F_MFLO) begin
                send(4'b0000, f, a, b, 1'b0);
                if (f == F_MTHI) exp_hi = a;
                if (f == F_MTLO) exp_lo = a;
                check("rnd_mv_hilo", {hi, lo}, {exp_hi, exp_lo});
                check("rnd_mv_busy", {63'b0, busy}, 64'd0);
            end else begin
                run_md("rnd_md", f, a, b, 1'b0);
            end
        end

        // Reset mid-divide
        send(4'b0000, F_DIV, 32'd12345, 32'd17, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {62'b0, busy, done}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_done", {63'b0, done}, 64'd0);
        rst = 1'b0;
        run_md("post_rst", F_MULT, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_control.md
Name: muldiv_control

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO register pair for the MIPS-style datapath.
- Decodes the R-type func field when alu_op selects func_op (4'b0000). Handles mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Runs iteratively, in parallel with the single-cycle ALU.
- Generalises single-cycle ALU decoding to a width-parametrised sequencer with a ready/valid request handshake, busy/done status and pipeline stall.

Parameters:
- WIDTH, 32, operand, HI and LO width; even, 8 or more.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  decoded instruction presented this cycle.
- req_ready  out  1  unit can accept a request; equals ~busy.
- alu_op  in  4  ALU op class; only 4'b0000 (func_op) is decoded.
- func  in  6  R-type func field.
- rs  in  WIDTH  multiplicand / dividend / mthi-mtlo source.
- rt  in  WIDTH  multiplier / divisor.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse when HI/LO hold a new mult/div result.
- stall  out  1  req_valid & busy & decoded op is any of the 8 muldiv funcs.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Func codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Reset (asynchronous, any time, including mid-operation): state IDLE; hi, lo, counter and internal registers cleared to 0; busy=0, done=0, req_ready=1, stall=0.
- Accept: a request is accepted when req_valid & req_ready & alu_op==4'b0000 & func is one of the 8 codes. Any other request is ignored with no state change.
- mthi / mtlo: write rs to hi / lo at the accept edge. No busy, no done.
- mfhi / mflo: no state change. The datapath reads the hi/lo ports combinationally.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, accepting mult/div:
  - Latch operands as absolute values for signed ops, raw values for unsigned ops.
  - Latch the result sign: for mult, sign(rs)^sign(rt); for div, quotient sign as for mult and remainder sign = sign(rs).
  - Clear the partial result and set the counter to 0. Go to RUN; busy=1 from the next cycle.
- RUN, mult: one shift-add step per cycle (multiplier LSB adds the multiplicand into the upper accumulator, then shift right by 1). Counter++. After WIDTH steps go to FIX.
- RUN, div: one restoring step per cycle (shift the remainder left by 1 and bring in the next dividend bit; trial subtract; quotient bit = no borrow). After WIDTH steps go to FIX.
- FIX:
  - Apply two's-complement negation to the 2·WIDTH product, or independently to the quotient and remainder, per the latched signs.
  - Write {hi,lo} = product, or lo = quotient and hi = remainder.
  - Go to IDLE.
- done=1 and busy=0 in the cycle after the FIX edge.
- Latency: accept edge to done-high cycle = WIDTH+2 cycles (34 for WIDTH=32).
- Divide by zero: iterations run normally. Result: lo = all-ones, hi = rs (original operand, unsigned interpretation), for both div and divu.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0. Width wraps modulo 2^WIDTH.
- A request arriving while busy: not accepted, stall=1, hi/lo unchanged. This includes mthi/mtlo, which are dropped until busy falls.
- Back-to-back: a request may be accepted in the same cycle done is high.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined:
  - mult leaves RUN for FIX as soon as the remaining (unshifted) multiplier bits are all zero. The product is aligned by a final shift of the remaining count in FIX.
  - Minimum latency is 2 cycles (multiplier zero). Results are identical to the fixed-latency case.
  - div is unchanged.
- Not defined: every mult/div takes exactly WIDTH RUN cycles.

Test Plan:
- WIDTH=32, mult rs=FFFFFFFD (-3), rt=00000005 -> done in cycle 34 after accept; hi=FFFFFFFF, lo=FFFFFFF1.
- multu rs=FFFFFFFF, rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. With MULDIV_EARLY_EXIT_EN, multu 3*5 -> lo=0000000F, hi=0, done well before 34 cycles.
- div rs=FFFFFFF9 (-7), rt=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. divu rs=7, rt=0 -> lo=FFFFFFFF, hi=00000007.
- mthi rs=12345678 issued while busy -> stall=1, req_ready=0, hi unchanged at completion. Same mthi reissued after done -> hi=12345678 next cycle, busy stays 0.
- rst asserted mid-RUN (cycle 10 of a div) -> immediately busy=0, hi=lo=0, done never pulses. A new mult is accepted the first cycle after rst deasserts.
- alu_op=4'b0001 with func=011000 -> ignored: busy stays 0, hi/lo unchanged.
